// File: rtl/regfile_access_ctrl_if.sv
// Bundle of all requester, store and register-file signals around regfile_access_ctrl.
// The slave modport is the controller's view; the master modport is the surrounding datapath.
interface regfile_access_ctrl_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_rd;
  logic [DW-1:0] alu_wdata;

  logic          ld_valid;
  logic          ld_ready;
  logic [AW-1:0] ld_rd;
  logic [DW-1:0] ld_wdata;

  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_rs;
  logic          st_rdata_valid;
  logic [DW-1:0] st_rdata;

  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rf_raddr;
  logic [DW-1:0] rf_rdata;

  modport slave (
    input  alu_valid, alu_rd, alu_wdata,
    output alu_ready,
    input  ld_valid, ld_rd, ld_wdata,
    output ld_ready,
    input  st_valid, st_rs,
    output st_ready, st_rdata_valid, st_rdata,
    output rf_we, rf_waddr, rf_wdata, rf_raddr,
    input  rf_rdata
  );

  modport master (
    output alu_valid, alu_rd, alu_wdata,
    input  alu_ready,
    output ld_valid, ld_rd, ld_wdata,
    input  ld_ready,
    output st_valid, st_rs,
    input  st_ready, st_rdata_valid, st_rdata,
    input  rf_we, rf_waddr, rf_wdata, rf_raddr,
    output rf_rdata
  );
endinterface

// File: rtl/regfile_access_ctrl.sv
// Register-file access sequencer: round-robin ALU/load write arbitration plus a store readout FSM.
// Optional macro STORE_FWD_EN forwards an in-flight write into the store readout instead of stalling.
module regfile_access_ctrl #(
  parameter int DW       = 32,
  parameter int AW       = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  regfile_access_ctrl_if.slave  bus
);

  typedef enum logic {
    GRANT_ALU,
    GRANT_LD
  } grant_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_RESP
  } st_state_e;

  grant_e        last_grant;
  logic          alu_grant;
  logic          ld_grant;
  logic          wr_accept;
  logic          wr_commit;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  logic          rf_we_q;
  logic [AW-1:0] rf_waddr_q;
  logic [DW-1:0] rf_wdata_q;
  logic [AW-1:0] rf_raddr_q;

  st_state_e     st_state;
  st_state_e     st_next;
  logic          st_ready_c;
  logic          st_accept;
  logic          st_stall;
  logic [DW-1:0] st_capture;
  logic [DW-1:0] st_rdata_q;

  // ---------------------------------------------------------------------------
  // Write arbitration: a lone requester always wins; on a tie the requester
  // that did not win last time is served.
  // ---------------------------------------------------------------------------
  // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    alu_grant = 1'b0;
    ld_grant  = 1'b0;
    if (!rst) begin
      if (bus.alu_valid && (!bus.ld_valid || last_grant == GRANT_LD)) begin
        alu_grant = 1'b1;
      end else if (bus.ld_valid) begin
        ld_grant = 1'b1;
      end
    end
  end

  assign wr_accept = alu_grant | ld_grant;
  assign wr_addr   = alu_grant ? bus.alu_rd    : bus.ld_rd;
  assign wr_data   = alu_grant ? bus.alu_wdata : bus.ld_wdata;
  // Writes to register 0 still handshake but never reach the file when it is hardwired.
  assign wr_commit = wr_accept && !(ZERO_REG && wr_addr == '0);

  assign bus.alu_ready = alu_grant;
  assign bus.ld_ready  = ld_grant;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GRANT_LD;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      if (alu_grant) begin
        last_grant <= GRANT_ALU;
      end else if (ld_grant) begin
        last_grant <= GRANT_LD;
      end
      rf_we_q <= wr_commit;
      if (wr_commit) begin
        rf_waddr_q <= wr_addr;
        rf_wdata_q <= wr_data;
      end
    end
  end

  assign bus.rf_we    = rf_we_q;
  assign bus.rf_waddr = rf_waddr_q;
  assign bus.rf_wdata = rf_wdata_q;

  // ---------------------------------------------------------------------------
  // Store readout: address registered on accept, data captured one cycle later,
  // response pulsed the cycle after that.
  // ---------------------------------------------------------------------------
`ifdef STORE_FWD_EN
  logic rd_hazard;

  assign st_stall   = 1'b0;
  assign rd_hazard  = rf_we_q && (rf_waddr_q == rf_raddr_q);
  assign st_capture = rd_hazard ? rf_wdata_q : bus.rf_rdata;
`else
  // Hold the store off while a write to the same register is accepted or still in the write stage.
  assign st_stall   = (rf_we_q && (rf_waddr_q == bus.st_rs)) ||
                      (wr_commit && (wr_addr == bus.st_rs));
  assign st_capture = bus.rf_rdata;
`endif

  always_comb begin
    st_next    = st_state;
    st_ready_c = 1'b0;
    st_accept  = 1'b0;
    unique case (st_state)
      ST_IDLE: begin
        st_ready_c = !rst && !st_stall;
        if (bus.st_valid && st_ready_c) begin
          st_accept = 1'b1;
          st_next   = ST_READ;
        end
      end
      ST_READ: st_next = ST_RESP;
      ST_RESP: st_next = ST_IDLE;
      default: st_next = ST_IDLE;
    endcase
  end

  // NOTE: st_rdata is a single register, so it is reset along with the rest; only true memories skip reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_state   <= ST_IDLE;
      rf_raddr_q <= '0;
      st_rdata_q <= '0;
    end else begin
      st_state <= st_next;
      if (st_accept) begin
        rf_raddr_q <= bus.st_rs;
      end
      if (st_state == ST_READ) begin
        st_rdata_q <= st_capture;
      end
    end
  end

  assign bus.st_ready       = st_ready_c;
  assign bus.st_rdata_valid = (st_state == ST_RESP);
  assign bus.st_rdata       = st_rdata_q;
  assign bus.rf_raddr       = rf_raddr_q;

endmodule
